// File: rtl/wash_run_if.sv
// Front-panel handoff bundle between the input stage (master) and the washer run controller (slave).
// Start/pause/ack are single-cycle pulses; lid_open is a level.
interface wash_run_if;
    logic       start;
    logic [1:0] mode;
    logic [4:0] weight;
    logic [9:0] bal_in;
    logic       pause;
    logic       lid_open;
    logic       ack;
    logic       busy;
    logic       done;
    logic       err;
    logic [9:0] bal_out;
    logic [2:0] phase;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;

    modport master (
        output start, mode, weight, bal_in, pause, lid_open, ack,
        input  busy, done, err, bal_out, phase, d0, d1, d2
    );

    modport slave (
        input  start, mode, weight, bal_in, pause, lid_open, ack,
        output busy, done, err, bal_out, phase, d0, d1, d2
    );
endinterface

// File: rtl/wash_run.sv
// Washer run controller: price/load check and charge, then timed WASH->RINSE->SPIN with pause/lid interlock.
// One CHECK cycle follows an accepted start; starts outside IDLE are dropped; DONE/ERR hold until ack.
module wash_run #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int WASH_S     = 20,
    parameter int RINSE_S    = 10,
    parameter int SPIN_S     = 15,
    parameter int PRICE_BASE = 5,
    parameter int MAX_KG     = 20
) (
    input  logic      clk,
    input  logic      rst,
    wash_run_if.slave ctl
);
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WASH, S_RINSE, S_SPIN, S_PAUSE, S_DONE, S_ERR
    } state_e;

    localparam int         TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [5:0] MAX_KG_W = 6'(MAX_KG);

    state_e          state_q, state_d;
    state_e          saved_q, saved_d;
    logic [1:0]      mode_q, mode_d;
    logic [4:0]      weight_q, weight_d;
    logic [9:0]      bal_q, bal_d;
    logic [9:0]      bal_out_q, bal_out_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [9:0]      prem_q, prem_d;
    logic [9:0]      trem_q, trem_d;
    state_e          nxt;
    state_e          shown;
    logic [9:0]      price;
    logic [9:0]      total;

    function automatic logic [9:0] phase_len(state_e s, logic [1:0] m);
        case (s)
            S_WASH:  return 10'(WASH_S * int'(m));
            S_RINSE: return 10'(RINSE_S * int'(m));
            S_SPIN:  return 10'(SPIN_S);
            default: return 10'd0;
        endcase
    endfunction

    // Zero-length phases are skipped; CHECK acts as the phase before WASH.
    function automatic state_e next_phase(state_e s, logic [1:0] m);
        state_e n;
        n = S_DONE;
        if (s == S_CHECK && phase_len(S_WASH, m) != 10'd0)
            n = S_WASH;
        else if ((s == S_CHECK || s == S_WASH) && phase_len(S_RINSE, m) != 10'd0)
            n = S_RINSE;
        else if (s != S_SPIN && phase_len(S_SPIN, m) != 10'd0)
            n = S_SPIN;
        return n;
    endfunction

    assign price = 10'(PRICE_BASE * (int'(mode_q) + 1)) + 10'(weight_q);
    assign total = phase_len(S_WASH, mode_q) + phase_len(S_RINSE, mode_q) + phase_len(S_SPIN, mode_q);

    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        mode_d    = mode_q;
        weight_d  = weight_q;
        bal_d     = bal_q;
        bal_out_d = bal_out_q;
        tick_d    = tick_q;
        prem_d    = prem_q;
        trem_d    = trem_q;
        nxt       = state_q;
        case (state_q)
            S_IDLE: begin
                if (ctl.start) begin
                    mode_d   = ctl.mode;
                    weight_d = ctl.weight;
                    bal_d    = ctl.bal_in;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if ({1'b0, weight_q} > MAX_KG_W || weight_q == 5'd0 || price > bal_q) begin
                    bal_out_d = bal_q;
                    trem_d    = 10'd0;
                    state_d   = S_ERR;
                end else begin
                    nxt       = next_phase(S_CHECK, mode_q);
                    bal_out_d = bal_q - price;
                    trem_d    = total;
                    prem_d    = phase_len(nxt, mode_q);
                    tick_d    = '0;
                    state_d   = nxt;
                end
            end
            S_WASH, S_RINSE, S_SPIN: begin
                if (tick_q == TW'(TICK_DIV - 1)) begin
                    tick_d = '0;
                    trem_d = trem_q - 10'd1;
                    prem_d = prem_q - 10'd1;
                    if (prem_q == 10'd1) begin
                        nxt    = next_phase(state_q, mode_q);
                        prem_d = phase_len(nxt, mode_q);
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
                state_d = nxt;
                // The count for this cycle is kept, then we park on whichever phase comes next.
                if (nxt != S_DONE && (ctl.pause || ctl.lid_open)) begin
                    saved_d = nxt;
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (ctl.pause && !ctl.lid_open)
                    state_d = saved_q;
            end
            S_DONE: begin
                trem_d = 10'd0;
                if (ctl.ack)
                    state_d = S_IDLE;
            end
            S_ERR: begin
                if (ctl.ack)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            saved_q   <= S_IDLE;
            mode_q    <= 2'd0;
            weight_q  <= 5'd0;
            bal_q     <= 10'd0;
            bal_out_q <= 10'd0;
            tick_q    <= '0;
            prem_q    <= 10'd0;
            trem_q    <= 10'd0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            mode_q    <= mode_d;
            weight_q  <= weight_d;
            bal_q     <= bal_d;
            bal_out_q <= bal_out_d;
            tick_q    <= tick_d;
            prem_q    <= prem_d;
            trem_q    <= trem_d;
        end
    end

    assign shown       = (state_q == S_PAUSE) ? saved_q : state_q;
    assign ctl.busy    = (state_q == S_WASH) || (state_q == S_RINSE) ||
                         (state_q == S_SPIN) || (state_q == S_PAUSE);
    assign ctl.done    = (state_q == S_DONE);
    assign ctl.err     = (state_q == S_ERR);
    assign ctl.bal_out = bal_out_q;
    assign ctl.phase   = {shown == S_SPIN, shown == S_RINSE, shown == S_WASH};
    assign ctl.d0      = 4'(trem_q % 10'd10);
    assign ctl.d1      = 4'((trem_q / 10'd10) % 10'd10);
    assign ctl.d2      = 4'(trem_q / 10'd100);
endmodule

// File: tb/tb_wash_run.sv
// Bench for wash_run: directed scenarios plus randomized runs checked against an elapsed-time reference model.
// Model tracks active cycles since the first phase; phase and remaining seconds derive from that count.
module tb_wash_run;
    localparam int TD = 4;
    localparam int WS = 2;
    localparam int RS = 1;
    localparam int SS = 3;
    localparam int PB = 5;
    localparam int MK = 20;

    localparam int M_IDLE   = 0;
    localparam int M_CHECK  = 1;
    localparam int M_RUN    = 2;
    localparam int M_PAUSED = 3;
    localparam int M_DONE   = 4;
    localparam int M_ERR    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wash_run_if ifc();

    wash_run #(
        .TICK_DIV(TD), .WASH_S(WS), .RINSE_S(RS), .SPIN_S(SS), .PRICE_BASE(PB), .MAX_KG(MK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctl(ifc.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int m_st, m_mode, m_weight, m_bal, m_balout, m_total, m_el;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_balout = 0; m_total = 0; m_el = 0;
        m_mode = 0; m_weight = 0; m_bal = 0;
    endtask

    // Advance the reference by one clock using the inputs currently applied.
    task automatic model_step();
        int price;
        case (m_st)
            M_IDLE: if (ifc.start) begin
                m_mode = ifc.mode; m_weight = ifc.weight; m_bal = ifc.bal_in; m_st = M_CHECK;
            end
            M_CHECK: begin
                price = PB * (m_mode + 1) + m_weight;
                if (m_weight > MK || m_weight == 0 || price > m_bal) begin
                    m_balout = m_bal; m_st = M_ERR;
                end else begin
                    m_balout = m_bal - price;
                    m_total  = WS * m_mode + RS * m_mode + SS;
                    m_el     = 0;
                    m_st     = M_RUN;
                end
            end
            M_RUN: begin
                m_el++;
                if (m_el == m_total * TD) m_st = M_DONE;
                else if (ifc.pause || ifc.lid_open) m_st = M_PAUSED;
            end
            M_PAUSED: if (ifc.pause && !ifc.lid_open) m_st = M_RUN;
            default: if (ifc.ack) m_st = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        int rem, ph, dig;
        logic active;
        active = (m_st == M_RUN) || (m_st == M_PAUSED);
        rem = active ? (m_total - m_el / TD) : 0;
        if (!active) ph = 0;
        else if (m_el < WS * m_mode * TD) ph = 1;
        else if (m_el < (WS + RS) * m_mode * TD) ph = 2;
        else ph = 4;
        dig = ((rem / 100) % 10) * 256 + ((rem / 10) % 10) * 16 + rem % 10;
        check_eq("busy", ifc.busy, active);
        check_eq("done", ifc.done, m_st == M_DONE);
        check_eq("err", ifc.err, m_st == M_ERR);
        check_eq("bal_out", ifc.bal_out, m_balout);
        check_eq("phase", ifc.phase, ph);
        check_eq("digits", {ifc.d2, ifc.d1, ifc.d0}, dig);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse_start(input int mo, input int w, input int b);
        ifc.start = 1'b1; ifc.mode = 2'(mo); ifc.weight = 5'(w); ifc.bal_in = 10'(b);
        cycle();
        ifc.start = 1'b0;
    endtask

    task automatic run_until_end(input int budget);
        for (int i = 0; i < budget && !(m_st == M_DONE || m_st == M_ERR); i++) cycle();
        check_eq("end_reached", ifc.done | ifc.err, 1);
    endtask

    task automatic ack_it();
        ifc.ack = 1'b1;
        cycle();
        ifc.ack = 1'b0;
    endtask

    initial begin
        ifc.start = 0; ifc.mode = 0; ifc.weight = 0; ifc.bal_in = 0;
        ifc.pause = 0; ifc.lid_open = 0; ifc.ack = 0;
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b1;

        // Mode 1 normal run, with a second start mid-WASH that must be ignored.
        pulse_start(1, 3, 50);
        repeat (3) cycle();
        pulse_start(3, 10, 999);
        run_until_end(200);
        check_eq("m1_bal", ifc.bal_out, 37);
        ack_it();

        // Spin-only mode drains the balance exactly.
        pulse_start(0, 4, 9);
        run_until_end(200);
        ack_it();

        // Overweight rejected.
        pulse_start(3, 21, 999);
        run_until_end(10);
        check_eq("ovw_bal", ifc.bal_out, 999);
        ack_it();

        // Price one above balance, then exactly equal.
        pulse_start(2, 5, 19);
        run_until_end(10);
        ack_it();
        pulse_start(2, 5, 20);
        run_until_end(200);
        check_eq("exact_bal", ifc.bal_out, 0);
        ack_it();

        // Zero weight rejected.
        pulse_start(1, 0, 500);
        run_until_end(10);
        ack_it();

        // Lid opened in RINSE with pause pulses that must not resume.
        pulse_start(1, 3, 50);
        repeat (11) cycle();
        for (int i = 0; i < 10; i++) begin
            ifc.lid_open = 1'b1;
            ifc.pause = (i == 3 || i == 6);
            cycle();
        end
        ifc.lid_open = 1'b0; ifc.pause = 1'b0;
        repeat (2) cycle();
        check_eq("lid_hold", ifc.phase, 2);
        ifc.pause = 1'b1;
        cycle();
        ifc.pause = 1'b0;
        run_until_end(200);
        ack_it();

        // Asynchronous reset in SPIN.
        pulse_start(1, 3, 50);
        repeat (15) cycle();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b1;

        // Randomized transactions with pause pulses, lid activity and stray starts.
        for (int t = 0; t < 16; t++) begin
            pulse_start($urandom_range(0, 3), $urandom_range(0, 23),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(0, 999) : $urandom_range(0, 60));
            for (int c = 0; c < 300 && !(m_st == M_DONE || m_st == M_ERR); c++) begin
                if (c < 120) begin
                    if ($urandom_range(0, 15) == 0) ifc.lid_open = ~ifc.lid_open;
                    ifc.pause = ($urandom_range(0, 24) == 0);
                end else begin
                    ifc.lid_open = 1'b0;
                    ifc.pause = (m_st == M_PAUSED);
                end
                ifc.start = ($urandom_range(0, 30) == 0);
                ifc.mode = 2'($urandom_range(0, 3));
                cycle();
                ifc.start = 1'b0;
            end
            ifc.lid_open = 1'b0; ifc.pause = 1'b0;
            check_eq("rnd_end", ifc.done | ifc.err, 1);
            ack_it();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
